aes_tf_stream_arbiter: RTL and testbench
========================================

Name: aes_tf_stream_arbiter

Overview:
- Packet-aware controller/arbiter that shares the single AXI-Stream output toward the UART TX path between two sources.
- Sources: s0 = AES cipher output, s1 = bypass/other traffic.
- Replaces free-running combinational selection: grant is decided only at packet boundaries and held until the tlast beat completes.
- Adds round-robin sharing and per-channel packet counters.

Parameters:
- DATA_W, 8: tdata width (UART byte stream).
- CNT_W, 16: width of each per-channel packet counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  cipher enable; meaningful only when wm==2'b00.
- wm  input  2  work mode: 00 = en-selected, 01 = cipher only, 10/11 = shared round-robin.
- s0_axis  my_axis_if.slave  DATA_W  cipher stream input.
- s1_axis  my_axis_if.slave  DATA_W  bypass stream input.
- m_axis  my_axis_if.master  DATA_W  arbitrated output stream.
- cnt_clr  input  1  synchronous clear of both packet counters.
- grant  output  2  one-hot current owner ({s1,s0}); 2'b00 when idle.
- busy  output  1  high while a packet is in flight (state != IDLE).
- pkt_cnt0  output  CNT_W  completed s0 packets (tlast handshakes), saturating.
- pkt_cnt1  output  CNT_W  completed s1 packets, saturating.

Behaviour:
- Reset state: IDLE; grant=0; busy=0; pkt_cnt0=pkt_cnt1=0; rr_last=1 (so s0 wins the first tie).
- Eligibility (sampled in IDLE only):
  - wm==01: s0 only.
  - wm==00: s0 if en=1, else s1.
  - wm==1x: both channels.
- Request: req_i = s_i.tvalid & eligible_i.
- FSM states: IDLE, CH0, CH1.
- IDLE:
  - m_axis.tvalid=0, tlast=0, tdata=0; both s*.tready=0.
  - req0 only -> CH0; req1 only -> CH1.
  - req0 & req1 -> channel != rr_last.
  - No request -> stay in IDLE.
- CHx:
  - Pure combinational pass-through: m_axis.{tdata,tvalid,tlast} = sx; sx.tready = m_axis.tready.
  - Non-granted channel: tready=0.
  - Beat transfers when sx.tvalid & m_axis.tready.
  - Transferred beat with tlast=1: next state IDLE, rr_last<=x, pkt_cntx increments.
- Latency:
  - One-cycle grant bubble: first beat of a packet appears on m_axis the cycle after the FSM leaves IDLE.
  - Beats within a packet: zero added latency, full throughput.
  - Minimum inter-packet gap: 1 idle cycle.
- Mode/en changes mid-packet: ignored until return to IDLE; the current packet always completes on its granted channel.
- Source tvalid drops mid-packet: grant held, m_axis.tvalid follows source; no timeout.
- Counters:
  - Saturate at all-ones; no wrap.
  - cnt_clr and an increment in the same cycle -> counter becomes 0 (clear wins).
- Reset mid-packet: immediate return to IDLE, all outputs to reset values; the partial packet is not counted. Downstream is responsible for framing recovery.
- AXIS rule: the arbiter never drops or duplicates beats, and never asserts tready on a non-granted source.

Decomposition:
- Shared package aes_uart_pkg:
  - enum arb_state_t {IDLE, CH0, CH1}.
  - Work-mode constants WM_SEL=2'b00, WM_CIPHER=2'b01, WM_SHARED=2'b10.
- Sub-module sat_counter (CNT_W, inc, clr): instantiated twice for pkt_cnt0/pkt_cnt1.
- Datapath mux: inline always_comb.

Test Plan:
- wm=01; s1 presents a 3-beat packet, then s0 presents 4 beats 0xA0..0xA3 (tlast on 0xA3) -> only s0 passes; s1.tready stays 0; pkt_cnt0=1, pkt_cnt1=0; grant=01 during the packet.
- wm=10; both sources continuously valid with 2-beat packets -> output alternates s0,s1,s0,s1 per packet with one idle cycle between packets; after 4 packets pkt_cnt0=2, pkt_cnt1=2.
- wm=00, en=1; switch en to 0 after beat 2 of a 5-beat s0 packet -> all 5 s0 beats complete; the next packet is taken from s1.
- m_axis.tready toggled randomly (50%) during a 6-beat s1 packet -> m_axis.tdata sequence is identical to the source with no loss or duplication; s1.tready mirrors m_axis.tready.
- Preload pkt_cnt0 near 16'hFFFF via repeated 1-beat packets, then send 2 more -> counter holds 16'hFFFF; assert cnt_clr coincident with a tlast handshake -> pkt_cnt0=0.
- Assert rst during beat 3 of a 5-beat s0 packet -> next cycle: state IDLE, grant=0, busy=0, m_axis.tvalid=0, counters=0; a subsequent packet arbitrates normally with s0 first.

Source files
------------

// File: rtl/aes_uart_pkg.sv
// Shared types and constants for the AES/UART stream path.
package aes_uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CH0  = 2'd1,
    CH1  = 2'd2
  } arb_state_t;

  localparam logic [1:0] WM_SEL    = 2'b00;
  localparam logic [1:0] WM_CIPHER = 2'b01;
  localparam logic [1:0] WM_SHARED = 2'b10;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned CNT_W_DEF  = 16;

endpackage

// File: rtl/aes_tf_stream_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/aes_tf_stream_arbiter.sv
// Packet-aware round-robin arbiter sharing one AXI-Stream output between the
// cipher stream (s0) and a bypass stream (s1).
module aes_tf_stream_arbiter
  import aes_uart_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        wm,
  input  logic [DATA_W-1:0] s0_tdata,
  input  logic              s0_tvalid,
  input  logic              s0_tlast,
  output logic              s0_tready,
  input  logic [DATA_W-1:0] s1_tdata,
  input  logic              s1_tvalid,
  input  logic              s1_tlast,
  output logic              s1_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready,
  input  logic              cnt_clr,
  output logic [1:0]        grant,
  output logic              busy,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1
);

  arb_state_t state_q, state_d;
  logic       rr_last_q, rr_last_d;
  logic       shared, elig0, elig1, req0, req1;
  logic       done0, done1;

  // Eligibility only matters in IDLE; mid-packet mode changes are ignored.
  assign shared = (wm & WM_SHARED) == WM_SHARED;
  assign elig0  = (wm == WM_CIPHER) || ((wm == WM_SEL) && en) || shared;
  assign elig1  = ((wm == WM_SEL) && !en) || shared;
  assign req0   = s0_tvalid && elig0;
  assign req1   = s1_tvalid && elig1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
    end
  end

  // Grant decided at packet boundaries; granted source passes straight through.
  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    m_tdata   = '0;
    m_tvalid  = 1'b0;
    m_tlast   = 1'b0;
    s0_tready = 1'b0;
    s1_tready = 1'b0;
    grant     = 2'b00;
    busy      = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          state_d = rr_last_q ? CH0 : CH1;
        end else if (req0) begin
          state_d = CH0;
        end else if (req1) begin
          state_d = CH1;
        end
      end
      CH0: begin
        grant     = 2'b01;
        busy      = 1'b1;
        m_tdata   = s0_tdata;
        m_tvalid  = s0_tvalid;
        m_tlast   = s0_tlast;
        s0_tready = m_tready;
        if (s0_tvalid && m_tready && s0_tlast) begin
          done0     = 1'b1;
          state_d   = IDLE;
          rr_last_d = 1'b0;
        end
      end
      CH1: begin
        grant     = 2'b10;
        busy      = 1'b1;
        m_tdata   = s1_tdata;
        m_tvalid  = s1_tvalid;
        m_tlast   = s1_tlast;
        s1_tready = m_tready;
        if (s1_tvalid && m_tready && s1_tlast) begin
          done1     = 1'b1;
          state_d   = IDLE;
          rr_last_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  sat_counter #(.CNT_W(CNT_W)) u_cnt0 (
    .clk (clk),
    .rst (rst),
    .inc (done0),
    .clr (cnt_clr),
    .cnt (pkt_cnt0)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt1 (
    .clk (clk),
    .rst (rst),
    .inc (done1),
    .clr (cnt_clr),
    .cnt (pkt_cnt1)
  );

endmodule

// File: tb/tb_aes_tf_stream_arbiter.sv
// Bench for aes_tf_stream_arbiter: queue-driven sources, output monitor and a
// packet-level arbitration model. Counters narrowed to 4 bits to reach saturation quickly.
module tb_aes_tf_stream_arbiter;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              clk, rst, en, cnt_clr;
  logic [1:0]        wm;
  logic [DATA_W-1:0] s0_tdata, s1_tdata, m_tdata;
  logic              s0_tvalid, s0_tlast, s0_tready;
  logic              s1_tvalid, s1_tlast, s1_tready;
  logic              m_tvalid, m_tlast, m_tready;
  logic [1:0]        grant;
  logic              busy;
  logic [CNT_W-1:0]  pkt_cnt0, pkt_cnt1;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic [1:0] gnt;
    int         cyc;
  } beat_t;

  beat_t       out_q[$];
  logic [8:0]  q0[$], q1[$];
  int unsigned gap0 = 0, gap1 = 0, rdy_pct = 100;
  int          total = 0, bad = 0, cyc = 0;
  bit          hs0, hs1;

  aes_tf_stream_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .wm(wm),
    .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tready(s0_tready),
    .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(s1_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .cnt_clr(cnt_clr), .grant(grant), .busy(busy),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Source drivers: present queue head, pop on handshake seen before the edge
  initial begin
    s0_tvalid = 1'b0; s0_tdata = '0; s0_tlast = 1'b0;
    forever begin
      @(negedge clk); hs0 = s0_tvalid && s0_tready;
      @(posedge clk); #1;
      if (hs0 && q0.size() > 0) void'(q0.pop_front());
      if (q0.size() > 0 && $urandom_range(99) >= gap0) begin
        s0_tvalid = 1'b1; s0_tlast = q0[0][8]; s0_tdata = q0[0][7:0];
      end else s0_tvalid = 1'b0;
    end
  end

  initial begin
    s1_tvalid = 1'b0; s1_tdata = '0; s1_tlast = 1'b0;
    forever begin
      @(negedge clk); hs1 = s1_tvalid && s1_tready;
      @(posedge clk); #1;
      if (hs1 && q1.size() > 0) void'(q1.pop_front());
      if (q1.size() > 0 && $urandom_range(99) >= gap1) begin
        s1_tvalid = 1'b1; s1_tlast = q1[0][8]; s1_tdata = q1[0][7:0];
      end else s1_tvalid = 1'b0;
    end
  end

  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_tready = ($urandom_range(99) < rdy_pct);
    end
  end

  // Output monitor plus the tready/tvalid ownership rules checked every cycle
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (m_tvalid && m_tready) begin
        b.data = m_tdata; b.last = m_tlast; b.gnt = grant; b.cyc = cyc;
        out_q.push_back(b);
      end
      if (!rst) begin
        total++;
        if (s0_tready !== ((grant == 2'b01) ? m_tready : 1'b0)) begin
          bad++; $display("FAIL s0_tready_rule: got %b want %b (grant %b)", s0_tready,
                          (grant == 2'b01) ? m_tready : 1'b0, grant);
        end
        total++;
        if (s1_tready !== ((grant == 2'b10) ? m_tready : 1'b0)) begin
          bad++; $display("FAIL s1_tready_rule: got %b want %b (grant %b)", s1_tready,
                          (grant == 2'b10) ? m_tready : 1'b0, grant);
        end
        total++;
        if (grant == 2'b00 && m_tvalid !== 1'b0) begin
          bad++; $display("FAIL idle_tvalid: got %b want 0", m_tvalid);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; cnt_clr = 1'b0;
    q0.delete(); q1.delete();
    s0_tvalid = 1'b0; s1_tvalid = 1'b0;
    gap0 = 0; gap1 = 0; rdy_pct = 100;
    tick(2);
    rst = 1'b0;
    tick(1);
    out_q.delete();
  endtask

  task automatic wait_out(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (out_q.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic push_pkt(input int ch, input logic [7:0] first, input int len);
    logic [7:0] d;
    d = first;
    for (int i = 0; i < len; i++) begin
      if (ch == 0) q0.push_back({(i == len - 1), d});
      else         q1.push_back({(i == len - 1), d});
      d = d + 8'd1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(3); rst = 1'b0; tick(1);
    @(negedge clk);
    total++; if (grant !== 2'b00)    begin bad++; $display("FAIL reset_grant: got %b want 00", grant); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (m_tvalid !== 1'b0)  begin bad++; $display("FAIL reset_tvalid: got %b want 0", m_tvalid); end
    total++; if (pkt_cnt0 !== '0)    begin bad++; $display("FAIL reset_cnt0: got %h want 0", pkt_cnt0); end
    total++; if (pkt_cnt1 !== '0)    begin bad++; $display("FAIL reset_cnt1: got %h want 0", pkt_cnt1); end
  endtask

  task automatic test_cipher_only();
    bit ok;
    do_reset(); wm = 2'b01; en = 1'b0;
    push_pkt(1, 8'h11, 3);
    tick(4);
    @(negedge clk);
    total++; if (grant !== 2'b00) begin bad++; $display("FAIL cipher_s1_ignored: grant got %b want 00", grant); end
    push_pkt(0, 8'hA0, 4);
    wait_out(4, 60, ok);
    total++; if (!ok) begin bad++; $display("FAIL cipher_timeout: got %0d beats want 4", out_q.size()); end
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      total++;
      if ({out_q[i].gnt, out_q[i].last, out_q[i].data} !== {2'b01, (i == 3), 8'hA0 + 8'(i)}) begin
        bad++; $display("FAIL cipher_beat%0d: got g=%b l=%b d=%h want g=01 l=%b d=%h", i,
                        out_q[i].gnt, out_q[i].last, out_q[i].data, (i == 3), 8'hA0 + 8'(i));
      end
    end
    tick(2); @(negedge clk);
    total++; if (pkt_cnt0 !== 4'd1) begin bad++; $display("FAIL cipher_cnt0: got %0d want 1", pkt_cnt0); end
    total++; if (pkt_cnt1 !== 4'd0) begin bad++; $display("FAIL cipher_cnt1: got %0d want 0", pkt_cnt1); end
    total++; if (q1.size() != 3)    begin bad++; $display("FAIL cipher_s1_untouched: got %0d beats left want 3", q1.size()); end
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [7:0] exp_d[8];
    logic [1:0] exp_g[8];
    do_reset(); wm = 2'b10;
    push_pkt(0, 8'h01, 2); push_pkt(0, 8'h03, 2);
    push_pkt(1, 8'h81, 2); push_pkt(1, 8'h83, 2);
    exp_d = '{8'h01, 8'h02, 8'h81, 8'h82, 8'h03, 8'h04, 8'h83, 8'h84};
    exp_g = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10};
    wait_out(8, 100, ok);
    total++; if (!ok) begin bad++; $display("FAIL rr_timeout: got %0d beats want 8", out_q.size()); end
    for (int i = 0; i < 8 && i < out_q.size(); i++) begin
      total++;
      if (out_q[i].data !== exp_d[i] || out_q[i].gnt !== exp_g[i]) begin
        bad++; $display("FAIL rr_beat%0d: got g=%b d=%h want g=%b d=%h", i,
                        out_q[i].gnt, out_q[i].data, exp_g[i], exp_d[i]);
      end
      if (i > 0) begin
        total++;
        if (out_q[i].cyc - out_q[i-1].cyc != ((i % 2 == 0) ? 2 : 1)) begin
          bad++; $display("FAIL rr_spacing%0d: got %0d cycles want %0d", i,
                          out_q[i].cyc - out_q[i-1].cyc, (i % 2 == 0) ? 2 : 1);
        end
      end
    end
    tick(2); @(negedge clk);
    total++; if (pkt_cnt0 !== 4'd2) begin bad++; $display("FAIL rr_cnt0: got %0d want 2", pkt_cnt0); end
    total++; if (pkt_cnt1 !== 4'd2) begin bad++; $display("FAIL rr_cnt1: got %0d want 2", pkt_cnt1); end
  endtask

  task automatic test_en_switch();
    bit ok;
    do_reset(); wm = 2'b00; en = 1'b1;
    push_pkt(0, 8'h21, 5);
    push_pkt(1, 8'h31, 3);
    wait_out(2, 50, ok);
    @(posedge clk); #2; en = 1'b0;
    wait_out(8, 100, ok);
    total++; if (!ok) begin bad++; $display("FAIL en_timeout: got %0d beats want 8", out_q.size()); end
    for (int i = 0; i < 8 && i < out_q.size(); i++) begin
      total++;
      if (i < 5 && (out_q[i].gnt !== 2'b01 || out_q[i].data !== 8'h21 + 8'(i))) begin
        bad++; $display("FAIL en_s0_beat%0d: got g=%b d=%h want g=01 d=%h", i,
                        out_q[i].gnt, out_q[i].data, 8'h21 + 8'(i));
      end else if (i >= 5 && (out_q[i].gnt !== 2'b10 || out_q[i].data !== 8'h31 + 8'(i - 5))) begin
        bad++; $display("FAIL en_s1_beat%0d: got g=%b d=%h want g=10 d=%h", i,
                        out_q[i].gnt, out_q[i].data, 8'h31 + 8'(i - 5));
      end
    end
    tick(2); @(negedge clk);
    total++; if (pkt_cnt0 !== 4'd1 || pkt_cnt1 !== 4'd1) begin
      bad++; $display("FAIL en_counts: got %0d/%0d want 1/1", pkt_cnt0, pkt_cnt1);
    end
  endtask

  task automatic test_tready_random();
    bit ok;
    logic [7:0] exp_d[6];
    do_reset(); wm = 2'b00; en = 1'b0;
    rdy_pct = 50; gap1 = 25;
    for (int i = 0; i < 6; i++) begin
      exp_d[i] = 8'($urandom);
      q1.push_back({(i == 5), exp_d[i]});
    end
    wait_out(6, 400, ok);
    total++; if (!ok) begin bad++; $display("FAIL trdy_timeout: got %0d beats want 6", out_q.size()); end
    rdy_pct = 100; gap1 = 0;
    tick(4); @(negedge clk);
    total++; if (out_q.size() != 6) begin bad++; $display("FAIL trdy_beat_count: got %0d want 6", out_q.size()); end
    for (int i = 0; i < 6 && i < out_q.size(); i++) begin
      total++;
      if ({out_q[i].gnt, out_q[i].last, out_q[i].data} !== {2'b10, (i == 5), exp_d[i]}) begin
        bad++; $display("FAIL trdy_beat%0d: got g=%b l=%b d=%h want g=10 l=%b d=%h", i,
                        out_q[i].gnt, out_q[i].last, out_q[i].data, (i == 5), exp_d[i]);
      end
    end
    total++; if (pkt_cnt1 !== 4'd1) begin bad++; $display("FAIL trdy_cnt1: got %0d want 1", pkt_cnt1); end
  endtask

  task automatic test_saturation();
    bit ok;
    bit seen;
    do_reset(); wm = 2'b01;
    for (int k = 0; k < 14; k++) push_pkt(0, 8'(k), 1);
    wait_out(14, 200, ok);
    tick(2); @(negedge clk);
    total++; if (pkt_cnt0 !== 4'd14) begin bad++; $display("FAIL sat_preload: got %0d want 14", pkt_cnt0); end
    push_pkt(0, 8'h70, 1); push_pkt(0, 8'h71, 1);
    wait_out(16, 50, ok);
    tick(2); @(negedge clk);
    total++; if (pkt_cnt0 !== CNT_MAX) begin bad++; $display("FAIL sat_hold: got %h want %h", pkt_cnt0, CNT_MAX); end
    push_pkt(0, 8'h72, 1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (m_tvalid && m_tready && m_tlast) begin
        seen = 1'b1; cnt_clr = 1'b1;
      end
    end
    @(posedge clk); #2; cnt_clr = 1'b0;
    @(negedge clk);
    total++; if (!seen) begin bad++; $display("FAIL clr_handshake_timeout: got none want tlast beat"); end
    total++; if (pkt_cnt0 !== '0) begin bad++; $display("FAIL clr_wins: got %0d want 0", pkt_cnt0); end
  endtask

  task automatic test_reset_mid_packet();
    bit ok;
    bit seen;
    do_reset(); wm = 2'b01;
    push_pkt(0, 8'h55, 1);
    wait_out(1, 20, ok);
    tick(2); @(negedge clk);
    total++; if (pkt_cnt0 !== 4'd1) begin bad++; $display("FAIL rstmid_pre_cnt0: got %0d want 1", pkt_cnt0); end
    push_pkt(0, 8'h41, 5);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (m_tvalid && m_tready && m_tdata == 8'h43) begin seen = 1'b1; rst = 1'b1; end
    end
    @(posedge clk); #2;
    q0.delete(); s0_tvalid = 1'b0;
    @(negedge clk);
    total++; if (!seen) begin bad++; $display("FAIL rstmid_no_beat3: got none want beat 43"); end
    total++; if ({grant, busy, m_tvalid} !== 4'b0000) begin
      bad++; $display("FAIL rstmid_outputs: got g=%b b=%b v=%b want 00/0/0", grant, busy, m_tvalid);
    end
    total++; if (pkt_cnt0 !== '0 || pkt_cnt1 !== '0) begin
      bad++; $display("FAIL rstmid_counters: got %0d/%0d want 0/0", pkt_cnt0, pkt_cnt1);
    end
    tick(1); rst = 1'b0; tick(1);
    out_q.delete();
    wm = 2'b10;
    push_pkt(0, 8'h61, 2); push_pkt(1, 8'h71, 1);
    wait_out(3, 50, ok);
    total++; if (!ok) begin bad++; $display("FAIL rstmid_after_timeout: got %0d beats want 3", out_q.size()); end
    for (int i = 0; i < 3 && i < out_q.size(); i++) begin
      total++;
      if (out_q[i].gnt !== ((i < 2) ? 2'b01 : 2'b10) ||
          out_q[i].data !== ((i < 2) ? 8'h61 + 8'(i) : 8'h71)) begin
        bad++; $display("FAIL rstmid_after_beat%0d: got g=%b d=%h want g=%b d=%h", i,
                        out_q[i].gnt, out_q[i].data, (i < 2) ? 2'b01 : 2'b10,
                        (i < 2) ? 8'h61 + 8'(i) : 8'h71);
      end
    end
  endtask

  // Packet-level model: shared mode alternates packets, starting from s0, while both have work
  task automatic test_random_rr();
    bit ok;
    int n0, n1, p0, p1, ch, last, len;
    logic [10:0] exp_q[$];
    logic [7:0]  d;
    do_reset(); wm = 2'($urandom_range(3, 2)); rdy_pct = 70;
    n0 = $urandom_range(5, 2); n1 = $urandom_range(5, 2);
    p0 = 0; p1 = 0; last = 1;
    while (p0 < n0 || p1 < n1) begin
      if (p0 < n0 && p1 < n1) ch = (last == 1) ? 0 : 1;
      else ch = (p0 < n0) ? 0 : 1;
      len = $urandom_range(4, 1);
      for (int i = 0; i < len; i++) begin
        d = 8'($urandom);
        if (ch == 0) q0.push_back({(i == len - 1), d});
        else         q1.push_back({(i == len - 1), d});
        exp_q.push_back({(ch == 0) ? 2'b01 : 2'b10, (i == len - 1), d});
      end
      if (ch == 0) p0++; else p1++;
      last = ch;
    end
    wait_out(exp_q.size(), 2000, ok);
    total++; if (!ok) begin bad++; $display("FAIL rand_timeout: got %0d beats want %0d", out_q.size(), exp_q.size()); end
    rdy_pct = 100;
    tick(4); @(negedge clk);
    total++; if (out_q.size() != exp_q.size()) begin
      bad++; $display("FAIL rand_beat_count: got %0d want %0d", out_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      total++;
      if ({out_q[i].gnt, out_q[i].last, out_q[i].data} !== exp_q[i]) begin
        bad++; $display("FAIL rand_beat%0d: got %h want %h", i,
                        {out_q[i].gnt, out_q[i].last, out_q[i].data}, exp_q[i]);
      end
    end
    total++; if (pkt_cnt0 !== CNT_W'(n0) || pkt_cnt1 !== CNT_W'(n1)) begin
      bad++; $display("FAIL rand_counts: got %0d/%0d want %0d/%0d", pkt_cnt0, pkt_cnt1, n0, n1);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; wm = 2'b00; cnt_clr = 1'b0;
    test_reset();
    test_cipher_only();
    test_round_robin();
    test_en_switch();
    test_tready_random();
    test_saturation();
    test_reset_mid_packet();
    for (int r = 0; r < 4; r++) test_random_rr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
